// File: rtl/tdc_pkg.sv
// -----------------------------------------------------------------------------
// tdc_pkg
// Shared definitions for the TDC shot controller and its input synchroniser.
//   - Window, pulse-width and hit-count constants.
//   - Counter and hit-record field widths, plus pre-sized compare constants
//     so the datapath compares like-width values.
//   - FSM state encoding and the packed hit record.
// -----------------------------------------------------------------------------
package tdc_pkg;

    localparam int RANGE_CYC = 512;                 // window length, cycles of clk_250M
    localparam int MAX_HITS  = 3;                   // hits accepted per shot
    localparam int START_W   = 4;                   // TDC_start pulse width
    localparam int RST_W     = 3;                   // rst_auto pulse width
    localparam int CNT_W     = $clog2(RANGE_CYC);   // coarse counter width
    localparam int INT_W     = 16;                  // spad_int width
    localparam int IDX_W     = 2;                   // hit index / hit count width

    // One counter times both the START and RST pulses.
    localparam int WCNT_W    = $clog2((START_W > RST_W) ? START_W : RST_W);

    localparam logic [CNT_W-1:0]  COARSE_MAX = CNT_W'(RANGE_CYC - 1);
    localparam logic [WCNT_W-1:0] START_LAST = WCNT_W'(START_W - 1);
    localparam logic [WCNT_W-1:0] RST_LAST   = WCNT_W'(RST_W - 1);
    localparam logic [IDX_W-1:0]  HITS_MAX   = IDX_W'(MAX_HITS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ARM   = 3'd2,
        ST_RST   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic [CNT_W-1:0] coarse;
        logic [INT_W-1:0] spad;
        logic [IDX_W-1:0] idx;
    } hit_rec_t;

endpackage

// File: rtl/tdc_in_sync.sv
// -----------------------------------------------------------------------------
// tdc_in_sync
// Brings the asynchronous SPAD front-end signals into the clk_250M domain.
// trig, time_gate and spad_int each pass through two flops; a third trig flop
// feeds the rising-edge detector.  spad_int has the same latency as trig so
// the count sampled with a detected edge is the one the front-end held while
// trig was high.
//
// Ports
//   i_clk        in   1      capture clock (clk_250M)
//   i_rst_n      in   1      asynchronous active-low reset
//   i_trig       in   1      async photon trigger
//   i_gate       in   1      async time_gate
//   i_spad       in   INT_W  async SPAD count, stable while trig high
//   o_trig_rise  out  1      one-cycle pulse on a synchronised trig rising edge
//   o_gate_s     out  1      synchronised time_gate
//   o_spad_s     out  INT_W  synchronised spad_int, aligned with o_trig_rise
// -----------------------------------------------------------------------------
module tdc_in_sync
    import tdc_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_trig,
    input  logic             i_gate,
    input  logic [INT_W-1:0] i_spad,
    output logic             o_trig_rise,
    output logic             o_gate_s,
    output logic [INT_W-1:0] o_spad_s
);

    logic             r_trig_p0;
    logic             r_trig_p1;
    logic             r_trig_p2;
    logic             r_gate_p0;
    logic             r_gate_p1;
    logic [INT_W-1:0] r_spad_p0;
    logic [INT_W-1:0] r_spad_p1;

    // Stage p0: first capture flop, may go metastable
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_trig_p0 <= 1'b0;
            r_gate_p0 <= 1'b0;
            r_spad_p0 <= '0;
        end else begin
            r_trig_p0 <= i_trig;
            r_gate_p0 <= i_gate;
            r_spad_p0 <= i_spad;
        end
    end

    // Stage p1: synchronised values
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_trig_p1 <= 1'b0;
            r_gate_p1 <= 1'b0;
            r_spad_p1 <= '0;
        end else begin
            r_trig_p1 <= r_trig_p0;
            r_gate_p1 <= r_gate_p0;
            r_spad_p1 <= r_spad_p0;
        end
    end

    // Stage p2: delayed trig for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_trig_p2 <= 1'b0;
        end else begin
            r_trig_p2 <= r_trig_p1;
        end
    end

    assign o_trig_rise = r_trig_p1 & ~r_trig_p2;
    assign o_gate_s    = r_gate_p1;
    assign o_spad_s    = r_spad_p1;

endmodule

// File: rtl/tdc_shot_ctrl.sv
// -----------------------------------------------------------------------------
// tdc_shot_ctrl
// Sequences one TDC measurement shot: pulses TDC_start, opens a RANGE_CYC
// cycle window, time-stamps up to MAX_HITS photon triggers with the coarse
// cycle count and the SPAD count, re-arms the front-end with rst_auto after
// every hit, and presents each hit on a one-entry valid/ready output register.
//
// Ports
//   clk_250M    in   1      system clock, 250 MHz
//   rst_n       in   1      asynchronous active-low reset, aborts any shot
//   shot_start  in   1      one-cycle shot request, ignored unless idle
//   busy        out  1      shot in progress (START through DONE)
//   TDC_start   out  1      start pulse to the SPAD/TDC front-end
//   rst_auto    out  1      front-end re-arm pulse, held off by time_gate
//   trig        in   1      async photon trigger
//   time_gate   in   1      async gate, blocks rst_auto while high
//   spad_int    in   16     async SPAD count
//   hit_valid   out  1      hit record available
//   hit_ready   in   1      downstream accepts the record
//   hit_coarse  out  CNT_W  coarse time of the hit, cycles since shot start
//   hit_int     out  16     captured SPAD count
//   hit_idx     out  2      hit number within the shot
//   hit_drop    out  1      sticky: a hit was lost to a full output register
//   shot_done   out  1      one-cycle end-of-shot pulse
//   shot_hits   out  2      hits captured in the shot, valid with shot_done
// -----------------------------------------------------------------------------
module tdc_shot_ctrl
    import tdc_pkg::*;
(
    input  logic             clk_250M,
    input  logic             rst_n,
    input  logic             shot_start,
    output logic             busy,
    output logic             TDC_start,
    output logic             rst_auto,
    input  logic             trig,
    input  logic             time_gate,
    input  logic [INT_W-1:0] spad_int,
    output logic             hit_valid,
    input  logic             hit_ready,
    output logic [CNT_W-1:0] hit_coarse,
    output logic [INT_W-1:0] hit_int,
    output logic [IDX_W-1:0] hit_idx,
    output logic             hit_drop,
    output logic             shot_done,
    output logic [IDX_W-1:0] shot_hits
);

    // Coarse time saturates at the last window cycle and never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == COARSE_MAX) ? v : v + 1'b1;
    endfunction

    logic              w_trig_rise;
    logic              w_gate_s;
    logic [INT_W-1:0]  w_spad_s;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_shot_go;
    logic              w_capture;
    logic              w_rst_auto;
    logic              w_out_full;

    logic [CNT_W-1:0]  r_coarse;
    logic [WCNT_W-1:0] r_wcnt;
    logic [IDX_W-1:0]  r_nhits;

    logic              r_hit_valid;
    logic              r_hit_drop;
    hit_rec_t          r_rec;

    tdc_in_sync u_in_sync (
        .i_clk       (clk_250M),
        .i_rst_n     (rst_n),
        .i_trig      (trig),
        .i_gate      (time_gate),
        .i_spad      (spad_int),
        .o_trig_rise (w_trig_rise),
        .o_gate_s    (w_gate_s),
        .o_spad_s    (w_spad_s)
    );

    // A capture while an unaccepted record is still held loses the new hit.
    assign w_out_full = r_hit_valid & ~hit_ready;

    // Stage: FSM state register
    always_ff @(posedge clk_250M or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stage: next-state and shot outputs
    always_comb begin
        w_state_nxt = r_state;
        w_shot_go   = 1'b0;
        w_capture   = 1'b0;
        w_rst_auto  = 1'b0;
        busy        = (r_state != ST_IDLE);
        TDC_start   = 1'b0;
        shot_done   = 1'b0;
        shot_hits   = '0;

        case (r_state)
            ST_IDLE: begin
                if (shot_start) begin
                    w_shot_go   = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                TDC_start = 1'b1;
                if (r_wcnt == START_LAST) begin
                    w_state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                // A trigger on the last window cycle still wins over window end.
                if (w_trig_rise) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RST;
                end else if (r_coarse == COARSE_MAX) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_RST: begin
                // Edges seen here are dropped: the front-end is not re-armed yet.
                w_rst_auto = ~w_gate_s;
                if (w_rst_auto && (r_wcnt == RST_LAST)) begin
                    if ((r_nhits == HITS_MAX) || (r_coarse >= COARSE_MAX)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_ARM;
                    end
                end
            end
            ST_DONE: begin
                shot_done   = 1'b1;
                shot_hits   = r_nhits;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        rst_auto = w_rst_auto;
    end

    // Stage: coarse time, hit count and pulse-width counters
    always_ff @(posedge clk_250M or negedge rst_n) begin
        if (!rst_n) begin
            r_coarse <= '0;
            r_nhits  <= '0;
            r_wcnt   <= '0;
        end else begin
            if (w_shot_go) begin
                r_coarse <= '0;
            end else if (r_state inside {ST_START, ST_ARM, ST_RST}) begin
                r_coarse <= sat_inc(r_coarse);
            end

            if (w_shot_go) begin
                r_nhits <= '0;
            end else if (w_capture) begin
                r_nhits <= r_nhits + 1'b1;
            end

            // Restart on every state change; in RST only cycles with rst_auto
            // actually driven count toward the pulse width.
            if (w_state_nxt != r_state) begin
                r_wcnt <= '0;
            end else if ((r_state == ST_START) || w_rst_auto) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
        end
    end

    // Stage: one-entry hit output register
    always_ff @(posedge clk_250M or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_valid <= 1'b0;
            r_hit_drop  <= 1'b0;
            r_rec       <= '0;
        end else begin
            if (w_shot_go) begin
                r_hit_drop <= 1'b0;
            end else if (w_capture && w_out_full) begin
                r_hit_drop <= 1'b1;
            end

            // An accept and a capture in the same cycle reload the register.
            if (w_capture && !w_out_full) begin
                r_rec.coarse <= r_coarse;
                r_rec.spad   <= w_spad_s;
                r_rec.idx    <= r_nhits;
                r_hit_valid  <= 1'b1;
            end else if (r_hit_valid && hit_ready) begin
                r_hit_valid <= 1'b0;
            end
        end
    end

    assign hit_valid  = r_hit_valid;
    assign hit_coarse = r_rec.coarse;
    assign hit_int    = r_rec.spad;
    assign hit_idx    = r_rec.idx;
    assign hit_drop   = r_hit_drop;

endmodule

// File: tb/tb_tdc_shot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tdc_shot_ctrl
// Directed and randomised shots against tdc_shot_ctrl.  Each shot is described
// as per-cycle stimulus arrays indexed by cycles since shot_start was taken;
// the expected hits, rst_auto cycles and end-of-shot cycle are derived from
// those arrays with the shot rules (2-flop input latency, edge detect, window,
// re-arm width, hit limit) and compared with what a negedge monitor observed.
// -----------------------------------------------------------------------------
module tb_tdc_shot_ctrl;

    localparam int RANGE     = 512;
    localparam int START_CYC = 4;
    localparam int RST_CYC   = 3;
    localparam int MAXH      = 3;
    localparam int NCYC      = 700;

    logic        clk_250M = 1'b0;
    logic        rst_n = 1'b0;
    logic        shot_start = 1'b0;
    logic        busy, TDC_start, rst_auto;
    logic        trig = 1'b0;
    logic        time_gate = 1'b0;
    logic [15:0] spad_int = '0;
    logic        hit_valid;
    logic        hit_ready = 1'b0;
    logic [8:0]  hit_coarse;
    logic [15:0] hit_int;
    logic [1:0]  hit_idx;
    logic        hit_drop, shot_done;
    logic [1:0]  shot_hits;

    tdc_shot_ctrl dut (
        .clk_250M   (clk_250M),
        .rst_n      (rst_n),
        .shot_start (shot_start),
        .busy       (busy),
        .TDC_start  (TDC_start),
        .rst_auto   (rst_auto),
        .trig       (trig),
        .time_gate  (time_gate),
        .spad_int   (spad_int),
        .hit_valid  (hit_valid),
        .hit_ready  (hit_ready),
        .hit_coarse (hit_coarse),
        .hit_int    (hit_int),
        .hit_idx    (hit_idx),
        .hit_drop   (hit_drop),
        .shot_done  (shot_done),
        .shot_hits  (shot_hits)
    );

    always #2 clk_250M = ~clk_250M;

    int cyc = 0;
    always @(posedge clk_250M) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- stimulus arrays ----------------
    bit          trig_a[NCYC];
    bit          gate_a[NCYC];
    bit          sst_a[NCYC];
    logic [15:0] spad_a[NCYC];

    function automatic bit tr_at(input int c);
        return (c >= 0 && c < NCYC) ? trig_a[c] : 1'b0;
    endfunction
    function automatic bit gate_at(input int c);
        return (c >= 0 && c < NCYC) ? gate_a[c] : 1'b0;
    endfunction
    function automatic logic [15:0] spad_at(input int c);
        return (c >= 0 && c < NCYC) ? spad_a[c] : 16'd0;
    endfunction

    task automatic clr_stim();
        for (int i = 0; i < NCYC; i++) begin
            trig_a[i] = 1'b0;
            gate_a[i] = 1'b0;
            sst_a[i]  = 1'b0;
            spad_a[i] = '0;
        end
    endtask

    // Photon: trig high for 2 cycles from cycle t, spad held, gate high g cycles.
    task automatic add_photon(input int t, input logic [15:0] sp, input int g);
        trig_a[t] = 1'b1;  trig_a[t+1] = 1'b1;
        spad_a[t] = sp;    spad_a[t+1] = sp;
        for (int k = 0; k < g; k++) gate_a[t+k] = 1'b1;
    endtask

    // ---------------- reference model ----------------
    int exp_n, exp_done;
    int exp_c[MAXH];
    int exp_s[MAXH];
    int exp_rst[$];

    task automatic compute_exp();
        int c, d, n, r, last;
        exp_rst.delete();
        exp_n = 0;
        exp_done = -1;
        c = START_CYC;
        forever begin
            d = -1;
            for (int x = c; x < RANGE; x++) begin
                if (tr_at(x-2) && !tr_at(x-3)) begin
                    d = x;
                    break;
                end
            end
            if (d < 0) begin
                exp_done = RANGE;
                break;
            end
            exp_c[exp_n] = d;
            exp_s[exp_n] = int'(spad_at(d-2));
            exp_n++;
            n = 0; r = d + 1; last = d;
            while (n < RST_CYC && r < NCYC + 8) begin
                if (!gate_at(r-2)) begin
                    exp_rst.push_back(r);
                    n++;
                    last = r;
                end
                r++;
            end
            if (exp_n == MAXH || last >= RANGE - 1) begin
                exp_done = last + 1;
                break;
            end
            c = last + 1;
        end
    endtask

    // ---------------- monitor ----------------
    typedef struct {
        int rel;
        int coarse;
        int sp;
        int idx;
    } rec_t;

    bit         mon_en = 1'b0;
    int         s_cur = 0;
    int         rst_q[$];
    int         tdc_q[$];
    rec_t       rec_q[$];
    int         done_rel = -1;
    int         done_hv = 0;
    int         busy_cnt = 0;
    bit         unstable = 1'b0;
    bit         pv_valid = 1'b0;
    bit         pv_hs = 1'b0;
    logic [26:0] pv_f = '0;

    always @(negedge clk_250M) begin
        if (!mon_en) begin
            rst_q.delete();
            tdc_q.delete();
            rec_q.delete();
            done_rel <= -1;
            done_hv  <= 0;
            busy_cnt <= 0;
            unstable <= 1'b0;
            pv_valid <= 1'b0;
            pv_hs    <= 1'b0;
            pv_f     <= '0;
        end else begin
            if (rst_auto) rst_q.push_back(cyc - s_cur);
            if (TDC_start) tdc_q.push_back(cyc - s_cur);
            if (hit_valid && hit_ready)
                rec_q.push_back('{cyc - s_cur, int'(hit_coarse), int'(hit_int), int'(hit_idx)});
            if (shot_done && done_rel < 0) begin
                done_rel <= cyc - s_cur;
                done_hv  <= int'(shot_hits);
            end
            if (busy) busy_cnt <= busy_cnt + 1;
            if (hit_valid && pv_valid && !pv_hs && ({hit_coarse, hit_int, hit_idx} != pv_f))
                unstable <= 1'b1;
            pv_valid <= hit_valid;
            pv_hs    <= hit_valid & hit_ready;
            pv_f     <= {hit_coarse, hit_int, hit_idx};
        end
    end

    // ---------------- shot runner ----------------
    task automatic drive(input int j);
        trig       = trig_a[j];
        time_gate  = gate_a[j];
        spad_int   = spad_a[j];
        shot_start = sst_a[j];
    endtask

    task automatic run_shot(input string tag, input bit rdy);
        int j;
        compute_exp();
        hit_ready = rdy;
        mon_en = 1'b0;
        @(negedge clk_250M);
        @(posedge clk_250M); #1;
        shot_start = 1'b1;
        @(posedge clk_250M); #1;
        s_cur = cyc;
        mon_en = 1'b1;
        j = 0;
        drive(0);
        while (j < NCYC - 1) begin
            @(negedge clk_250M); #1;
            if (done_rel >= 0) break;
            @(posedge clk_250M); #1;
            j++;
            drive(j);
        end
        trig = 1'b0; time_gate = 1'b0; spad_int = '0; shot_start = 1'b0;
        repeat (3) @(posedge clk_250M);
        #1;

        chk({tag, "_done_seen"}, 64'(done_rel >= 0), 64'd1);
        chk({tag, "_done_cyc"}, done_rel, exp_done);
        chk({tag, "_shot_hits"}, done_hv, exp_n);
        chk({tag, "_busy_cycles"}, busy_cnt, exp_done + 1);
        chk({tag, "_busy_after"}, busy, 1'b0);
        chk({tag, "_tdc_cycles"}, tdc_q.size(), START_CYC);
        chk({tag, "_tdc_first"}, (tdc_q.size() > 0) ? tdc_q[0] : -1, 0);
        chk({tag, "_rst_count"}, rst_q.size(), exp_rst.size());
        if (rst_q.size() == exp_rst.size())
            for (int i = 0; i < exp_rst.size(); i++)
                chk($sformatf("%s_rst_%0d", tag, i), rst_q[i], exp_rst[i]);

        if (rdy) begin
            chk({tag, "_rec_count"}, rec_q.size(), exp_n);
            if (rec_q.size() == exp_n)
                for (int i = 0; i < exp_n; i++) begin
                    chk($sformatf("%s_rec%0d_time", tag, i), rec_q[i].rel, exp_c[i] + 1);
                    chk($sformatf("%s_rec%0d_coarse", tag, i), rec_q[i].coarse, exp_c[i]);
                    chk($sformatf("%s_rec%0d_int", tag, i), rec_q[i].sp, exp_s[i]);
                    chk($sformatf("%s_rec%0d_idx", tag, i), rec_q[i].idx, i);
                end
            chk({tag, "_drop"}, hit_drop, 1'b0);
            chk({tag, "_valid_after"}, hit_valid, 1'b0);
        end else begin
            chk({tag, "_rec_count"}, rec_q.size(), 0);
            chk({tag, "_valid_held"}, hit_valid, 64'(exp_n > 0));
            chk({tag, "_drop"}, hit_drop, 64'(exp_n >= 2));
            chk({tag, "_stable"}, unstable, 1'b0);
            if (exp_n > 0) begin
                chk({tag, "_held_coarse"}, hit_coarse, exp_c[0]);
                chk({tag, "_held_int"}, hit_int, exp_s[0]);
                chk({tag, "_held_idx"}, hit_idx, 0);
            end
            hit_ready = 1'b1;
            @(posedge clk_250M); #1;
            chk({tag, "_valid_release"}, hit_valid, 1'b0);
            hit_ready = 1'b0;
        end
        chk({tag, "_shot_hits_idle"}, shot_hits, 0);
        mon_en = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int t;
        repeat (3) @(posedge clk_250M);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_tdc_start", TDC_start, 1'b0);
        chk("rst_rst_auto", rst_auto, 1'b0);
        chk("rst_hit_valid", hit_valid, 1'b0);
        chk("rst_shot_done", shot_done, 1'b0);
        chk("rst_hit_drop", hit_drop, 1'b0);
        chk("rst_shot_hits", shot_hits, 0);
        chk("rst_hit_coarse", hit_coarse, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk_250M);

        // No photons: full window, no hits.
        clr_stim();
        run_shot("nophot", 1'b1);

        // Three photons, ready always high.
        clr_stim();
        add_photon(25, 16'd5, 0);
        add_photon(75, 16'd6, 0);
        add_photon(225, 16'd7, 0);
        run_shot("three", 1'b1);

        // time_gate held 5 cycles after a trigger delays rst_auto.
        clr_stim();
        add_photon(40, 16'h00A5, 5);
        run_shot("gate", 1'b1);

        // Output register held: second hit dropped.
        clr_stim();
        add_photon(25, 16'd11, 0);
        add_photon(50, 16'd12, 0);
        run_shot("noready", 1'b0);

        // Detect on the last window cycle.
        clr_stim();
        add_photon(509, 16'h1234, 0);
        run_shot("winend", 1'b1);

        // shot_start during ARM is ignored.
        clr_stim();
        sst_a[100] = 1'b1;
        add_photon(200, 16'hBEEF, 0);
        run_shot("restart", 1'b1);

        // Reset mid-shot while rst_auto and a held record are active.
        clr_stim();
        hit_ready = 1'b0;
        @(posedge clk_250M); #1;
        shot_start = 1'b1;
        @(posedge clk_250M); #1;
        shot_start = 1'b0;
        for (int j = 1; j <= 24; j++) begin
            @(posedge clk_250M); #1;
            trig = (j == 20 || j == 21);
        end
        chk("abort_rst_auto_before", rst_auto, 1'b1);
        chk("abort_valid_before", hit_valid, 1'b1);
        chk("abort_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_rst_auto", rst_auto, 1'b0);
        chk("abort_valid", hit_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        @(posedge clk_250M); #1;
        rst_n = 1'b1;
        @(posedge clk_250M); #1;
        shot_start = 1'b1;
        @(posedge clk_250M); #1;
        shot_start = 1'b0;
        @(posedge clk_250M); #1;
        chk("abort_tdc_before", TDC_start, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_tdc_start", TDC_start, 1'b0);
        @(posedge clk_250M); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk_250M);

        clr_stim();
        add_photon(25, 16'd5, 0);
        add_photon(75, 16'd6, 0);
        add_photon(225, 16'd7, 0);
        run_shot("after_abort", 1'b1);

        // Random shots.
        for (int s = 0; s < 6; s++) begin
            clr_stim();
            t = int'($urandom_range(0, 60));
            while (t < 530) begin
                add_photon(t, 16'($urandom), int'($urandom_range(0, 6)));
                t += int'($urandom_range(3, 180));
            end
            run_shot($sformatf("rand%0d", s), 1'($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
